// File: rtl/mul_seq.sv
// mul_seq -- sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//
// One shift-add iteration per clock. Signed mode converts both operands to
// their magnitudes on the accept edge and negates the product when the
// operand signs differ, so a single unsigned datapath serves both modes.
//
// Ports:
//   CLOCK       in   system clock, rising edge
//   RESET_B     in   synchronous active-low reset
//   MD          in   multiplicand, sampled on the accept edge
//   MQ          in   multiplier, sampled on the accept edge
//   SIGNED_MODE in   1 = two's-complement operands/result
//   START       in   request, accepted in IDLE or DONE
//   ANS         out  product, held until the next DONE entry or reset
//   BUSY        out  high while iterating
//   DONE        out  one-cycle pulse when ANS has just been updated
//
// Optional build macro MUL_SEQ_EARLY_TERM_EN: leave CALC as soon as the
// remaining multiplier bits are all zero, aligning the accumulator with a
// final shift of the remaining iteration count. Products are identical.
module mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               CLOCK,
  input  logic               RESET_B,
  input  logic [WIDTH-1:0]   MD,
  input  logic [WIDTH-1:0]   MQ,
  input  logic               SIGNED_MODE,
  input  logic               START,
  output logic [2*WIDTH-1:0] ANS,
  output logic               BUSY,
  output logic               DONE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   md_r;
  logic [WIDTH-1:0]   mq_r;
  logic               neg_r;
  logic [CW-1:0]      cnt;

  logic               accept;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_wide;
  logic [2*WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0]   mq_shift;
  logic [2*WIDTH-1:0] prod;
  logic               last_iter;

  // Two's-complement magnitude as WIDTH-bit unsigned; the most negative
  // value maps onto 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic            sgn);
    logic signed [WIDTH-1:0] s;
    s = signed'(v);
    if (sgn && (s < 0))
      return $unsigned(-s);
    return v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic              neg);
    logic signed [2*WIDTH-1:0] sp;
    sp = signed'(p);
    if (neg)
      return $unsigned(-sp);
    return p;
  endfunction

  assign accept = START && ((state == S_IDLE) || (state == S_DONE));

  // Iteration datapath: add into the upper half keeping the carry, then
  // shift the (2*WIDTH+1)-bit result right by one.
  always_comb begin
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mq_r[0] ? {1'b0, md_r} : '0);
    acc_wide  = {sum, acc[WIDTH-1:0]};
    acc_shift = (2*WIDTH)'(acc_wide >> 1);
    mq_shift  = mq_r >> 1;
`ifdef MUL_SEQ_EARLY_TERM_EN
    last_iter = (cnt == LAST_CNT) || (mq_shift == '0);
`else
    last_iter = (cnt == LAST_CNT);
`endif
    // Remaining shift count is zero on the WIDTH-th iteration.
    prod      = acc_shift >> (LAST_CNT - cnt);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_B)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_CALC;
      S_CALC:  if (last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = START ? S_CALC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_B) begin
      acc   <= '0;
      md_r  <= '0;
      mq_r  <= '0;
      neg_r <= 1'b0;
      cnt   <= '0;
      ANS   <= '0;
    end else if (accept) begin
      acc   <= '0;
      md_r  <= magnitude(MD, SIGNED_MODE);
      mq_r  <= magnitude(MQ, SIGNED_MODE);
      neg_r <= SIGNED_MODE && (MD[WIDTH-1] ^ MQ[WIDTH-1]);
      cnt   <= '0;
    end else if (state == S_CALC) begin
      acc  <= acc_shift;
      mq_r <= mq_shift;
      cnt  <= cnt + CW'(1);
      if (last_iter)
        ANS <= apply_sign(prod, neg_r);
    end
  end

  assign BUSY = (state == S_CALC);
  assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

  logic       clk = 1'b0;
  logic       rst_b;

  logic [3:0] md4, mq4;
  logic       s4, st4;
  logic [7:0] ans4;
  logic       busy4, done4;

  logic [7:0] md8, mq8;
  logic       s8, st8;
  logic [15:0] ans8;
  logic       busy8, done8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_seq #(.WIDTH(4)) dut4 (
    .CLOCK(clk), .RESET_B(rst_b), .MD(md4), .MQ(mq4), .SIGNED_MODE(s4),
    .START(st4), .ANS(ans4), .BUSY(busy4), .DONE(done4)
  );

  mul_seq #(.WIDTH(8)) dut8 (
    .CLOCK(clk), .RESET_B(rst_b), .MD(md8), .MQ(mq8), .SIGNED_MODE(s8),
    .START(st8), .ANS(ans8), .BUSY(busy8), .DONE(done8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer multiplication of the interpreted operands.
  function automatic logic [31:0] ref_prod(input int w, input logic [7:0] a,
                                           input logic [7:0] b, input bit sgn);
    int x, y, p;
    x = int'(a) & ((1 << w) - 1);
    y = int'(b) & ((1 << w) - 1);
    if (sgn) begin
      if (x >= (1 << (w - 1))) x -= (1 << w);
      if (y >= (1 << (w - 1))) y -= (1 << w);
    end
    p = x * y;
    return 32'(p & ((1 << (2 * w)) - 1));
  endfunction

  function automatic int ref_lat(input int w, input logic [7:0] b, input bit sgn);
`ifdef MUL_SEQ_EARLY_TERM_EN
    int mag, lat;
    mag = int'(b) & ((1 << w) - 1);
    if (sgn && (mag >= (1 << (w - 1)))) mag = (1 << w) - mag;
    lat = 1;
    while ((mag >> lat) != 0) lat++;
    return lat;
`else
    if (sgn || b[0] || !b[0]) return w;
    return w;
`endif
  endfunction

  task automatic drive(input int w, input logic [7:0] a, input logic [7:0] b,
                       input bit sgn, input bit st);
    if (w == 4) begin
      md4 = a[3:0]; mq4 = b[3:0]; s4 = sgn; st4 = st;
    end else begin
      md8 = a; mq8 = b; s8 = sgn; st8 = st;
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic [31:0] get_ans(input int w);
    return (w == 4) ? 32'(ans4) : 32'(ans8);
  endfunction

  // Called at a negedge. Returns at the negedge inside the DONE cycle.
  task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b,
                       input bit sgn, input bit hold, input string tag);
    logic [31:0] exp;
    int lat, bc;
    bit seen;
    exp  = ref_prod(w, a, b, sgn);
    lat  = ref_lat(w, b, sgn);
    bc   = 0;
    seen = 1'b0;
    drive(w, a, b, sgn, 1'b1);
    @(negedge clk);
    chk({tag, "_busy_first"}, 32'(get_busy(w)), 32'd1);
    // Operand changes after the accept edge must not matter.
    drive(w, 8'($urandom), 8'($urandom), 1'($urandom), hold);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (get_done(w)) seen = 1'b1;
      else begin
        if (get_busy(w)) bc++;
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_ans"}, get_ans(w), exp);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'(lat));
    chk({tag, "_busy_in_done"}, 32'(get_busy(w)), 32'd0);
  endtask

  // After a DONE with START low: pulse ends, result is held.
  task automatic post_idle(input int w, input string tag);
    logic [31:0] held;
    held = get_ans(w);
    drive(w, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(get_done(w)), 32'd0);
    chk({tag, "_ans_held"}, get_ans(w), held);
  endtask

  initial begin
    bit hold, sgn, w8, done_after_rst;
    int w;
    rst_b = 1'b0;
    drive(4, 8'h0, 8'h0, 1'b0, 1'b0);
    drive(8, 8'h0, 8'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_ans4", 32'(ans4), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_ans8", 32'(ans8), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    do_op(4, 8'h09, 8'h0B, 1'b0, 1'b0, "u4_9x11");
    post_idle(4, "u4_9x11");
    chk("u4_9x11_const", 32'(ans4), 32'h63);

    do_op(4, 8'h09, 8'h0B, 1'b0, 1'b1, "b2b_a");
    do_op(4, 8'h06, 8'h03, 1'b0, 1'b0, "b2b_b");
    chk("b2b_b_const", 32'(ans4), 32'h12);
    post_idle(4, "b2b_b");

    do_op(4, 8'h09, 8'h0B, 1'b1, 1'b0, "s4_m7xm5");
    chk("s4_m7xm5_const", 32'(ans4), 32'h23);
    post_idle(4, "s4_m7xm5");
    do_op(4, 8'h08, 8'h07, 1'b1, 1'b0, "s4_m8x7");
    chk("s4_m8x7_const", 32'(ans4), 32'hC8);
    post_idle(4, "s4_m8x7");
    do_op(4, 8'h08, 8'h08, 1'b1, 1'b0, "s4_m8xm8");
    chk("s4_m8xm8_const", 32'(ans4), 32'h40);
    post_idle(4, "s4_m8xm8");
    do_op(4, 8'h00, 8'h0F, 1'b1, 1'b0, "s4_0xm1");
    post_idle(4, "s4_0xm1");

    do_op(8, 8'hFF, 8'hFF, 1'b0, 1'b0, "u8_ffxff");
    chk("u8_ffxff_const", 32'(ans8), 32'hFE01);
    post_idle(8, "u8_ffxff");
    do_op(8, 8'h80, 8'h01, 1'b1, 1'b0, "s8_m128x1");
    chk("s8_m128x1_const", 32'(ans8), 32'hFF80);
    post_idle(8, "s8_m128x1");
    do_op(8, 8'h03, 8'h05, 1'b0, 1'b0, "u8_3x5");
    post_idle(8, "u8_3x5");
    do_op(8, 8'h5A, 8'h01, 1'b0, 1'b0, "u8_mq1");
    post_idle(8, "u8_mq1");
    do_op(8, 8'hC3, 8'h80, 1'b0, 1'b0, "u8_mq80");
    post_idle(8, "u8_mq80");

    // Reset during the second CALC cycle aborts the operation.
    drive(4, 8'h09, 8'h0B, 1'b0, 1'b1);
    @(negedge clk);
    drive(4, 8'h09, 8'h0B, 1'b0, 1'b0);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy4), 32'd0);
    chk("midrst_done", 32'(done4), 32'd0);
    chk("midrst_ans", 32'(ans4), 32'd0);
    rst_b = 1'b1;
    done_after_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4) done_after_rst = 1'b1;
    end
    chk("midrst_no_done", 32'(done_after_rst), 32'd0);
    do_op(4, 8'h07, 8'h0D, 1'b1, 1'b0, "after_rst");
    post_idle(4, "after_rst");

    for (int i = 0; i < 30; i++) begin
      w8   = 1'($urandom);
      w    = w8 ? 8 : 4;
      sgn  = 1'($urandom);
      hold = (i != 29) && ($urandom_range(0, 3) == 0);
      do_op(w, 8'($urandom), 8'($urandom), sgn, hold, $sformatf("rnd%0d", i));
      if (hold) begin
        do_op(w, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0,
              $sformatf("rnd%0d_b2b", i));
      end
      post_idle(w, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
